z80_mem_responder: RTL
======================

# z80_mem_responder

Synthesizable memory responder for the Z80 external bus. It samples the CPU-side address, strobes and write data, and answers with read data and WAIT_L stretching. It also commits writes into an internal byte array. It sits opposite the datapath's addr_out/data_out/data_in pins and is the bench-and-FPGA replacement for hand-driven data_in stimulus.

## Interface
Parameters:
- ADDR_W, 10: implemented address bits; depth 2**ADDR_W bytes.
- RD_WAIT, 1: wait cycles inserted on non-M1 memory reads (0–15).
- M1_WAIT, 0: wait cycles inserted on opcode fetch (m1_L=0) reads (0–15).
- WR_WAIT, 0: wait cycles inserted on writes (0–15).

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- rst_L, in, 1: reset; asynchronous assert, active-low.
- addr, in, 16: CPU address bus (datapath addr_out).
- data_from_cpu, in, 8: CPU write data (datapath data_out).
- mreq_L, rd_L, wr_L, m1_L, rfsh_L, in, 1 each: Z80 bus strobes, active-low.
- data_to_cpu, out, 8: read data (feeds datapath data_in).
- data_oe, out, 1: data_to_cpu valid/driven; the top level tristates data_in when 0.
- wait_L, out, 1: active-low WAIT to CPU.
- err, out, 1: sticky protocol error flag.
- bd_we, in, 1: backdoor preload write enable.
- bd_addr, in, ADDR_W: backdoor preload address.
- bd_data, in, 8: backdoor preload data.

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE:
  - A request is sampled when mreq_L=0, rfsh_L=1, and exactly one of rd_L/wr_L is 0.
  - On a request, latch addr, op (RD/WR) and m1_L, and load cnt with the matching wait parameter.
  - If cnt>0: go to WAIT and drive wait_L<=0. Otherwise go to ACCESS.
- Refresh cycles (rfsh_L=0) are ignored in IDLE.
- If rd_L=0 and wr_L=0 together with mreq_L=0: set err<=1 and stay in IDLE. The cycle gets no response.
- WAIT:
  - Decrement cnt each edge.
  - When cnt==1: go to ACCESS and drive wait_L<=1.
  - If mreq_L rises while in WAIT: abort to IDLE, drive wait_L<=1, and commit no write.
- ACCESS:
  - RD: data_to_cpu<=mem[a] and data_oe<=1.
  - WR: mem[a]<=data_from_cpu, sampled at this edge.
  - Then go to HOLD.
- HOLD: hold data_to_cpu and data_oe until mreq_L=1, then drive data_oe<=0 and go to IDLE.
- Address range:
  - In range: addr[15:ADDR_W]==0.
  - Out of range read: returns 8'hFF.
  - Out of range write: dropped.
- Backdoor:
  - bd_we writes the array on any edge, in any state.
  - If bd_we and an ACCESS write target the same address on the same edge, the ACCESS write wins.
- err clears only on reset.

## Timing
- Reset values: data_to_cpu=8'h00, data_oe=0, wait_L=1, err=0, state=IDLE, cnt=0. Array contents are not reset.
- Request seen at edge k, read data valid after edge k+1+n, where n is the applicable wait count. With RD_WAIT=0, data is valid after edge k+1.
- wait_L is low for exactly n cycles: it falls after edge k and rises after edge k+n.
- A write commits at edge k+1+n. It is visible to a read starting at edge k+2+n or later.
- Back-to-back accesses need mreq_L high for at least one edge, which returns the FSM to IDLE.
- Reset asserted mid-access:
  - Outputs go to reset values immediately (asynchronous).
  - A pending write is not committed unless its ACCESS edge already occurred.

## Structure
- Package z80_bus_pkg holds:
  - enum resp_state_t {IDLE, WAIT, ACCESS, HOLD};
  - enum bus_op_t {OP_RD, OP_WR};
  - localparam OPEN_BUS = 8'hFF.
- Sub-module z80_mem_array:
  - Single-clock array, 2**ADDR_W x 8.
  - Two write ports with priority (access > backdoor) and one read port.
  - Registered reads are performed in ACCESS.

## Test plan
- Reset mid-WAIT (RD_WAIT=3, asserted after 1 wait cycle) -> wait_L=1, data_oe=0 and state IDLE immediately. Subsequent read of 10'h005 behaves normally.
- Backdoor 10'h0DD<=8'hEE, then a read at addr 16'h00DD with RD_WAIT=1 -> wait_L low for 1 cycle. data_to_cpu=8'hEE with data_oe=1 two edges after the request, holding until mreq_L rises.
- Write 8'hEE to 16'h00BB (WR_WAIT=0), then read 16'h00BB -> 8'hEE. A write to 16'hCCBB (out of range) changes nothing. A read of 16'hCCBB returns 8'hFF.
- Opcode fetch: m1_L=0, addr 16'h0000 holding 8'hED, M1_WAIT=0 -> data after 1 edge with no wait_L pulse. A following refresh cycle (rfsh_L=0, mreq_L=0) -> no response and no error.
- mreq_L deasserts during a 2-cycle write wait -> abort. The target byte is unchanged and wait_L returns to 1.
- rd_L=0 and wr_L=0 with mreq_L=0 -> err=1 (sticky), data_oe stays 0, and the array is unchanged.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 memory responder.
package z80_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      HOLD
   } resp_state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } bus_op_t;

   localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/z80_mem_responder_if.sv
// Z80 external bus as seen between the CPU datapath (master) and a memory responder (slave).
interface z80_bus_if;
   logic [15:0] addr;
   logic [7:0]  data_from_cpu;
   logic        mreq_L;
   logic        rd_L;
   logic        wr_L;
   logic        m1_L;
   logic        rfsh_L;
   logic [7:0]  data_to_cpu;
   logic        data_oe;
   logic        wait_L;

   modport master (
      output addr, data_from_cpu, mreq_L, rd_L, wr_L, m1_L, rfsh_L,
      input  data_to_cpu, data_oe, wait_L
   );

   modport slave (
      input  addr, data_from_cpu, mreq_L, rd_L, wr_L, m1_L, rfsh_L,
      output data_to_cpu, data_oe, wait_L
   );
endinterface

// File: rtl/z80_mem_array.sv
// Byte array with a prioritised pair of write ports (access over backdoor) and one registered read port.
module z80_mem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [7:0]        acc_data,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [2**ADDR_W];
   logic       bd_blocked;

   assign bd_blocked = acc_we && (acc_addr == bd_addr);

   always_ff @(posedge clk) begin
      if (acc_we)
         mem[acc_addr] <= acc_data;
      if (bd_we && !bd_blocked)
         mem[bd_addr] <= bd_data;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/z80_mem_responder.sv
// Z80 memory responder: decodes bus cycles, stretches them with WAIT and serves/commits bytes.
//   state  | meaning
//   IDLE   | no cycle in progress; sample strobes for a new request
//   WAIT   | wait_L held low, counting down the wait budget
//   ACCESS | read array / commit write on this edge
//   HOLD   | keep read data driven until mreq_L rises
module z80_mem_responder
   import z80_bus_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int RD_WAIT = 1,
   parameter int M1_WAIT = 0,
   parameter int WR_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst_L,
   z80_bus_if.slave          bus,
   output logic              err,
   input  logic              bd_we,
   input  logic [ADDR_W-1:0] bd_addr,
   input  logic [7:0]        bd_data
);

   resp_state_t       state, state_nxt;
   bus_op_t           op_q, op_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              in_range_q, in_range_nxt;
   logic              open_bus_q, open_bus_nxt;
   logic              wait_q, wait_nxt;
   logic              oe_q, oe_nxt;
   logic              err_nxt;
   logic              acc_we, rd_en;
   logic [7:0]        rd_data;
   logic              req_rd, req_wr, bus_err, req_in_range;
   logic [3:0]        req_wait;

   assign req_in_range = (bus.addr[15:ADDR_W] == '0);

   always_comb begin
      req_rd  = !bus.mreq_L && bus.rfsh_L && !bus.rd_L && bus.wr_L;
      req_wr  = !bus.mreq_L && bus.rfsh_L && bus.rd_L && !bus.wr_L;
      bus_err = !bus.mreq_L && !bus.rd_L && !bus.wr_L;
      if (req_wr)
         req_wait = 4'(WR_WAIT);
      else if (!bus.m1_L)
         req_wait = 4'(M1_WAIT);
      else
         req_wait = 4'(RD_WAIT);
   end

   always_comb begin
      state_nxt    = state;
      op_nxt       = op_q;
      cnt_nxt      = cnt;
      addr_nxt     = addr_q;
      in_range_nxt = in_range_q;
      open_bus_nxt = open_bus_q;
      wait_nxt     = wait_q;
      oe_nxt       = oe_q;
      err_nxt      = err;
      acc_we       = 1'b0;
      rd_en        = 1'b0;
      case (state)
         IDLE: begin
            if (bus_err) begin
               err_nxt = 1'b1;
            end else if (req_rd || req_wr) begin
               addr_nxt     = bus.addr[ADDR_W-1:0];
               in_range_nxt = req_in_range;
               op_nxt       = req_wr ? OP_WR : OP_RD;
               cnt_nxt      = req_wait;
               if (req_wait != 4'd0) begin
                  state_nxt = WAIT;
                  wait_nxt  = 1'b0;
               end else begin
                  state_nxt = ACCESS;
               end
            end
         end
         WAIT: begin
            // A CPU that drops mreq_L mid-wait abandons the cycle; nothing is committed.
            if (bus.mreq_L) begin
               state_nxt = IDLE;
               wait_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_nxt = ACCESS;
                  wait_nxt  = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (op_q == OP_WR) begin
               acc_we = in_range_q;
            end else begin
               rd_en        = 1'b1;
               open_bus_nxt = !in_range_q;
               oe_nxt       = 1'b1;
            end
            state_nxt = HOLD;
         end
         HOLD: begin
            if (bus.mreq_L) begin
               oe_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state      <= IDLE;
         op_q       <= OP_RD;
         cnt        <= '0;
         addr_q     <= '0;
         in_range_q <= 1'b0;
         open_bus_q <= 1'b0;
         wait_q     <= 1'b1;
         oe_q       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_q       <= op_nxt;
         cnt        <= cnt_nxt;
         addr_q     <= addr_nxt;
         in_range_q <= in_range_nxt;
         open_bus_q <= open_bus_nxt;
         wait_q     <= wait_nxt;
         oe_q       <= oe_nxt;
         err        <= err_nxt;
      end
   end

   z80_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk      (clk),
      .rst_L    (rst_L),
      .acc_we   (acc_we),
      .acc_addr (addr_q),
      .acc_data (bus.data_from_cpu),
      .bd_we    (bd_we),
      .bd_addr  (bd_addr),
      .bd_data  (bd_data),
      .rd_en    (rd_en),
      .rd_addr  (addr_q),
      .rd_data  (rd_data)
   );

   assign bus.data_to_cpu = open_bus_q ? OPEN_BUS : rd_data;
   assign bus.data_oe     = oe_q;
   assign bus.wait_L      = wait_q;

endmodule
